// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the data-memory store buffer
//
// Purpose : size codes, output-register FSM encoding, default entry layout and a
//           small helper used by the store buffer and its FIFO.
// Ports   : none (package).

package dmem_pkg;

    // Size codes as seen by the byte-lane controller.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_NONE = 2'b11;

    // Output-register FSM encoding.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    // Default word-address width.
    localparam int DMEM_AW = 30;

    // Entry layout at the default address width; the RTL packs entries in the
    // same {addr, size, data} order so parametrised widths stay consistent.
    typedef struct packed {
        logic [DMEM_AW-1:0] addr;
        logic [1:0]         size;
        logic [31:0]        data;
    } sb_entry_t;

    // A size code of 11 carries no write and is never buffered.
    function automatic logic sz_is_write(input logic [1:0] sz);
        return sz != SZ_NONE;
    endfunction

endpackage

// File: rtl/dmem_store_buffer_if.sv
// rtl/dmem_store_buffer_if.sv - pipeline, memory and load-check signals of the store buffer
//
// Purpose : bundles the store request handshake, the data-memory write port and the
//           load hazard/forward port into one interface.
// Modports: slave  - the store buffer itself
//           master - the environment (MEM stage, lane controller, load unit)

interface dmem_store_buffer_if #(
    parameter int AW = 30
);
    // store request from MEM stage
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [1:0]    st_size;
    logic [31:0]   st_data;
    // write port to the byte-lane controller
    logic [AW-1:0] dm_addr;
    logic [1:0]    dm_wen;
    logic [31:0]   dm_wdata;
    logic          dm_gnt;
    // load check
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hazard;
    logic          ld_fwd_hit;
    logic [31:0]   ld_fwd_data;
    // drain status
    logic          sb_empty;

    modport slave (
        input  st_valid, st_addr, st_size, st_data, dm_gnt, ld_valid, ld_addr,
        output st_ready, dm_addr, dm_wen, dm_wdata, ld_hazard, ld_fwd_hit, ld_fwd_data, sb_empty
    );

    modport master (
        output st_valid, st_addr, st_size, st_data, dm_gnt, ld_valid, ld_addr,
        input  st_ready, dm_addr, dm_wen, dm_wdata, ld_hazard, ld_fwd_hit, ld_fwd_data, sb_empty
    );

endinterface

// File: rtl/dmem_store_buffer_sb_fifo.sv
// rtl/dmem_store_buffer_sb_fifo.sv - circular entry FIFO of the store buffer
//
// Purpose : DEPTH-entry circular FIFO with push/pop, full/empty and count. All
//           entries are also exported in age order (index 0 = head/oldest) with a
//           matching valid vector so the parent can run address comparators.
// Ports   : clk, rst_n      clock, synchronous active-low reset
//           push_i/_data_i  write an entry (caller never pushes when full)
//           pop_i           drop the head (caller never pops when empty)
//           head_o          current head entry
//           full_o/empty_o  occupancy flags
//           count_o         number of valid entries
//           entries_o       DEPTH entries, flat, oldest in the low slice
//           valid_o         per-slice valid bits for entries_o

module sb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [W-1:0]           push_data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [DEPTH*W-1:0]     entries_o,
    output logic [DEPTH-1:0]       valid_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Rotate storage so slice k is the k-th oldest entry.
    always_comb begin
        entries_o = '0;
        valid_o   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            entries_o[k*W +: W] = mem_q[rd_ptr_q + PW'(k)];
            valid_o[k]          = (count_q > CW'(k));
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - posted-store queue ahead of the data-memory lane controller
//
// Purpose : accepts stores from the MEM stage, buffers up to DEPTH behind an output
//           register and drains them one write per granted cycle in acceptance order.
//           Loads that hit a pending store are flagged so MEM stalls.
// Ports   : clk    single clock, rising edge
//           rst_n  synchronous active-low reset
//           bus    dmem_store_buffer_if.slave: st_* store handshake, dm_* write port,
//                  ld_* hazard/forward check, sb_empty drain status
// Config  : DMEM_SB_FWD_EN - when defined, a load whose youngest matching store is a
//           full word gets that word forwarded instead of a stall.

module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 30
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dmem_store_buffer_if.slave     bus
);

    localparam int DW = 32;
    localparam int AO = DW + 2;      // addr offset inside a packed entry
    localparam int EW = AW + 2 + DW; // packed entry width {addr, size, data}
    localparam int CW = $clog2(DEPTH) + 1;

    logic [0:0]    state_q,    state_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic [1:0]    out_size_q, out_size_d;
    logic [DW-1:0] out_data_q, out_data_d;

    logic [EW-1:0]       fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [DEPTH*EW-1:0] fifo_entries;
    logic [DEPTH-1:0]    fifo_valid;

    logic hs;      // store handshake
    logic enq;     // handshake carrying a real write
    logic take;    // output register free to load this cycle
    logic pop;
    logic bypass;  // incoming store goes straight into the output register
    logic push;

    assign bus.st_ready = !fifo_full;
    assign hs     = bus.st_valid && !fifo_full;
    assign enq    = hs && sz_is_write(bus.st_size);
    // Idle register is always free; an issuing one frees up on grant.
    assign take   = (state_q == ST_IDLE) || bus.dm_gnt;
    // Queued stores always go first, which keeps acceptance order.
    assign pop    = take && !fifo_empty;
    assign bypass = take && fifo_empty && enq;
    assign push   = enq && !bypass;

    sb_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({bus.st_addr, bus.st_size, bus.st_data}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .entries_o   (fifo_entries),
        .valid_o     (fifo_valid)
    );

    always_comb begin
        state_d    = state_q;
        out_addr_d = out_addr_q;
        out_size_d = out_size_q;
        out_data_d = out_data_q;
        if (take) begin
            if (pop) begin
                out_addr_d = fifo_head[AO +: AW];
                out_size_d = fifo_head[DW +: 2];
                out_data_d = fifo_head[0 +: DW];
                state_d    = ST_ISSUE;
            end else if (bypass) begin
                out_addr_d = bus.st_addr;
                out_size_d = bus.st_size;
                out_data_d = bus.st_data;
                state_d    = ST_ISSUE;
            end else begin
                state_d    = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            out_addr_q <= '0;
            out_size_q <= SZ_NONE;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            out_addr_q <= out_addr_d;
            out_size_q <= out_size_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.dm_addr  = out_addr_q;
    assign bus.dm_wen   = (state_q == ST_ISSUE) ? out_size_q : SZ_NONE;
    assign bus.dm_wdata = out_data_q;
    assign bus.sb_empty = (fifo_count == '0) && (state_q == ST_IDLE);

    // Address comparators: output register (oldest) plus every valid FIFO slice.
    logic             out_match;
    logic [DEPTH-1:0] fifo_match;
    logic             any_match;

    assign out_match = (state_q == ST_ISSUE) && (out_addr_q == bus.ld_addr);

    always_comb begin
        fifo_match = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fifo_match[k] = fifo_valid[k] && (fifo_entries[k*EW + AO +: AW] == bus.ld_addr);
        end
    end

    assign any_match = out_match || (|fifo_match);

`ifdef DMEM_SB_FWD_EN
    logic [1:0]    yng_size;
    logic [DW-1:0] yng_data;
    logic          fwd_ok;

    // Later slices are younger, so the last match in the scan wins.
    always_comb begin
        yng_size = SZ_NONE;
        yng_data = '0;
        if (out_match) begin
            yng_size = out_size_q;
            yng_data = out_data_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (fifo_match[k]) begin
                yng_size = fifo_entries[k*EW + DW +: 2];
                yng_data = fifo_entries[k*EW +: DW];
            end
        end
    end

    // Only a full-word store fully covers the loaded word.
    assign fwd_ok          = any_match && (yng_size == SZ_WORD);
    assign bus.ld_fwd_hit  = bus.ld_valid && fwd_ok;
    assign bus.ld_fwd_data = (bus.ld_valid && fwd_ok) ? yng_data : '0;
    assign bus.ld_hazard   = bus.ld_valid && any_match && !fwd_ok;
`else
    logic unused_fwd_fields;

    assign unused_fwd_fields = ^fifo_entries;
    assign bus.ld_fwd_hit    = 1'b0;
    assign bus.ld_fwd_data   = '0;
    assign bus.ld_hazard     = bus.ld_valid && any_match;
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - directed self-checking bench for dmem_store_buffer

module tb_dmem_store_buffer;
    import dmem_pkg::*;

`ifdef DMEM_SB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_store_buffer_if #(.AW(DMEM_AW)) sb_if ();

    dmem_store_buffer #(
        .DEPTH (4),
        .AW    (DMEM_AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sb_if)
    );

    int total  = 0;
    int bad    = 0;
    int wr_cnt = 0;
    int base;
    sb_entry_t vec [5];

    // A write is accepted at the edge following this falling edge.
    always @(negedge clk) begin
        if (sb_if.dm_gnt && sb_if.dm_wen != SZ_NONE) wr_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic store(input logic [DMEM_AW-1:0] a, input logic [1:0] s, input logic [31:0] d);
        sb_if.st_valid = 1'b1;
        sb_if.st_addr  = a;
        sb_if.st_size  = s;
        sb_if.st_data  = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        sb_if.st_valid = 1'b0;
        sb_if.st_addr  = '0;
        sb_if.st_size  = SZ_NONE;
        sb_if.st_data  = '0;
        sb_if.dm_gnt   = 1'b0;
        sb_if.ld_valid = 1'b0;
        sb_if.ld_addr  = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rst_wen",   64'(sb_if.dm_wen),   64'(2'b11));
        chk("rst_addr",  64'(sb_if.dm_addr),  64'(0));
        chk("rst_wdata", 64'(sb_if.dm_wdata), 64'(0));
        chk("rst_empty", 64'(sb_if.sb_empty), 64'(1));
        chk("rst_ready", 64'(sb_if.st_ready), 64'(1));

        // 1: single word store, bypass into output register, granted at once
        sb_if.dm_gnt = 1'b1;
        store(30'h10, SZ_WORD, 32'hDEADBEEF);
        #1;
        chk("t1_ready", 64'(sb_if.st_ready), 64'(1));
        cyc();
        sb_if.st_valid = 1'b0;
        #1;
        chk("t1_wen",   64'(sb_if.dm_wen),   64'(2'b10));
        chk("t1_addr",  64'(sb_if.dm_addr),  64'(30'h10));
        chk("t1_wdata", 64'(sb_if.dm_wdata), 64'(32'hDEADBEEF));
        chk("t1_busy",  64'(sb_if.sb_empty), 64'(0));
        cyc();
        #1;
        chk("t1_idle_wen", 64'(sb_if.dm_wen),   64'(2'b11));
        chk("t1_empty",    64'(sb_if.sb_empty), 64'(1));
        chk("t1_writes",   64'(wr_cnt),         64'(1));

        // 2: five stores with no grant fill output register plus all four slots
        sb_if.dm_gnt = 1'b0;
        base = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            vec[i].addr = 30'h40 + 30'(i);
            vec[i].size = 2'(i % 3);
            vec[i].data = 32'hA500_0000 + 32'(i);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            store(vec[i].addr, vec[i].size, vec[i].data);
            #1;
            chk("t2_ready", 64'(sb_if.st_ready), 64'(1));
        end
        cyc();
        sb_if.st_valid = 1'b0;
        #1;
        chk("t2_full",     64'(sb_if.st_ready), 64'(0));
        chk("t2_hold_wen", 64'(sb_if.dm_wen),   64'(vec[0].size));
        cyc();
        #1;
        chk("t2_stall_addr", 64'(sb_if.dm_addr), 64'(vec[0].addr));
        chk("t2_stall_nowr", 64'(wr_cnt - base), 64'(0));
        sb_if.dm_gnt = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("t2_wen",   64'(sb_if.dm_wen),   64'(vec[j].size));
            chk("t2_addr",  64'(sb_if.dm_addr),  64'(vec[j].addr));
            chk("t2_wdata", 64'(sb_if.dm_wdata), 64'(vec[j].data));
            if (j == 1) chk("t2_ready_after_gnt", 64'(sb_if.st_ready), 64'(1));
            cyc();
        end
        #1;
        chk("t2_idle_wen", 64'(sb_if.dm_wen),   64'(2'b11));
        chk("t2_empty",    64'(sb_if.sb_empty), 64'(1));
        chk("t2_writes",   64'(wr_cnt - base),  64'(5));
        sb_if.dm_gnt = 1'b0;

        // 3: word 0x1C in output register, byte 0x20 queued in the FIFO
        cyc();
        store(30'h1C, SZ_WORD, 32'h11111111);
        cyc();
        store(30'h20, SZ_BYTE, 32'h00000055);
        cyc();
        sb_if.st_valid = 1'b0;
        sb_if.ld_valid = 1'b1;
        sb_if.ld_addr  = 30'h20;
        #1;
        chk("t3_hit_fifo", 64'(sb_if.ld_hazard), 64'(1));
        sb_if.ld_addr = 30'h24;
        #1;
        chk("t3_miss", 64'(sb_if.ld_hazard), 64'(0));
        sb_if.ld_valid = 1'b0;
        sb_if.ld_addr  = 30'h20;
        #1;
        chk("t3_noload", 64'(sb_if.ld_hazard), 64'(0));
        sb_if.ld_valid = 1'b1;
        sb_if.ld_addr  = 30'h1C;
        #1;
        chk("t3_out_haz",  64'(sb_if.ld_hazard),   64'(!FWD));
        chk("t3_out_hit",  64'(sb_if.ld_fwd_hit),  64'(FWD));
        chk("t3_out_data", 64'(sb_if.ld_fwd_data), FWD ? 64'(32'h11111111) : 64'(0));

        // 4: word 0x30 queued, then a younger half store to the same word
        sb_if.ld_valid = 1'b0;
        cyc();
        store(30'h30, SZ_WORD, 32'h12345678);
        cyc();
        sb_if.st_valid = 1'b0;
        sb_if.ld_valid = 1'b1;
        sb_if.ld_addr  = 30'h30;
        #1;
        chk("t4_word_haz",  64'(sb_if.ld_hazard),   64'(!FWD));
        chk("t4_word_hit",  64'(sb_if.ld_fwd_hit),  64'(FWD));
        chk("t4_word_data", 64'(sb_if.ld_fwd_data), FWD ? 64'(32'h12345678) : 64'(0));
        cyc();
        store(30'h30, SZ_HALF, 32'h0000BEEF);
        cyc();
        sb_if.st_valid = 1'b0;
        #1;
        chk("t4_half_haz",  64'(sb_if.ld_hazard),   64'(1));
        chk("t4_half_hit",  64'(sb_if.ld_fwd_hit),  64'(0));
        chk("t4_half_data", 64'(sb_if.ld_fwd_data), 64'(0));
        sb_if.ld_valid = 1'b0;
        base = wr_cnt;
        sb_if.dm_gnt = 1'b1;
        for (int n = 0; n < 20 && !sb_if.sb_empty; n++) cyc();
        #1;
        chk("t4_drained", 64'(sb_if.sb_empty), 64'(1));
        chk("t4_writes",  64'(wr_cnt - base),  64'(4));
        sb_if.dm_gnt = 1'b0;

        // 5: size 11 is accepted but never written
        cyc();
        store(30'h50, SZ_NONE, 32'hFFFFFFFF);
        #1;
        chk("t5_ready", 64'(sb_if.st_ready), 64'(1));
        base = wr_cnt;
        cyc();
        sb_if.st_valid = 1'b0;
        #1;
        chk("t5_wen",   64'(sb_if.dm_wen),   64'(2'b11));
        chk("t5_empty", 64'(sb_if.sb_empty), 64'(1));
        sb_if.dm_gnt = 1'b1;
        cyc();
        cyc();
        #1;
        chk("t5_nowr", 64'(wr_cnt - base), 64'(0));
        sb_if.dm_gnt = 1'b0;

        // 6: reset with three stores pending discards all of them
        cyc();
        store(30'h60, SZ_WORD, 32'h60606060);
        cyc();
        store(30'h61, SZ_BYTE, 32'h00000061);
        cyc();
        store(30'h62, SZ_HALF, 32'h00006262);
        cyc();
        sb_if.st_valid = 1'b0;
        #1;
        chk("t6_pending", 64'(sb_if.sb_empty), 64'(0));
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        chk("t6_wen",   64'(sb_if.dm_wen),   64'(2'b11));
        chk("t6_empty", 64'(sb_if.sb_empty), 64'(1));
        chk("t6_ready", 64'(sb_if.st_ready), 64'(1));
        chk("t6_addr",  64'(sb_if.dm_addr),  64'(0));
        base = wr_cnt;
        sb_if.dm_gnt = 1'b1;
        repeat (5) cyc();
        #1;
        chk("t6_nowr",       64'(wr_cnt - base),  64'(0));
        chk("t6_still_empty", 64'(sb_if.sb_empty), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
